// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer: opcodes, FSM state
// encoding and response error codes.
package alu_pkg;

  // Opcode map. 0000..1010 are legal; 1011..1111 are rejected.
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_NOT = 4'b0011;
  localparam logic [3:0] OP_SHL = 4'b0100;
  localparam logic [3:0] OP_SHR = 4'b0101;
  localparam logic [3:0] OP_CMP = 4'b0110;
  localparam logic [3:0] OP_ADD = 4'b0111;
  localparam logic [3:0] OP_SUB = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1001;
  localparam logic [3:0] OP_DIV = 4'b1010;

  // Issuer FSM states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Response error codes.
  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_DIV0    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // True for opcodes the ALU understands.
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_DIV);
  endfunction

endpackage

// File: rtl/alu_command_issuer.sv
// ALU command issuer: accepts one command at a time, screens out illegal
// opcodes and divide-by-zero, pulses alu_start, waits (bounded) for
// alu_done and holds the response until the consumer takes it.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. cmd_ready is 1 only in IDLE. rsp_valid is 1 only in RESP, and
// rsp_result/rsp_error do not change while rsp_valid is 1 and rsp_ready is 0.
//
// Timing for a legal op whose alu_done comes the cycle after alu_start:
// cycle 1 IDLE (accept), cycle 2 ISSUE (alu_start), cycle 3 WAIT (alu_done),
// cycle 4 RESP (rsp_valid).
module alu_command_issuer
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd_op,
  input  logic [WIDTH-1:0]     cmd_a,
  input  logic [WIDTH-1:0]     cmd_b,
  output logic [3:0]           operation_type,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic                 alu_start,
  input  logic                 alu_done,
  input  logic [2*WIDTH-1:0]   alu_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2*WIDTH-1:0]   rsp_result,
  output logic [1:0]           rsp_error,
  output logic [1:0]           dbg_state
);

  // Wait counter counts 0..TIMEOUT-1; TIMEOUT is expected to be at least 2.
  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_op;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*WIDTH-1:0]  r_result;
  logic [1:0]          r_error;

  logic w_accept;
  logic w_illegal;
  logic w_div0;
  logic w_timeout;

  assign w_accept  = (r_state == S_IDLE) && cmd_valid;
  assign w_illegal = !op_is_legal(cmd_op);
  assign w_div0    = (cmd_op == OP_DIV) && (cmd_b == '0);
  assign w_timeout = (r_cnt == CNT_LAST);

  // Next-state logic; alu_done only matters in WAIT, where it beats timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_illegal || w_div0) w_next = S_RESP;
          else                     w_next = S_ISSUE;
        end
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (alu_done || w_timeout) w_next = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded handshake and start outputs.
  always_comb begin
    cmd_ready = 1'b0;
    alu_start = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      S_IDLE:  cmd_ready = 1'b1;
      S_ISSUE: alu_start = 1'b1;
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Operand capture on acceptance; held untouched until the next acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op <= '0;
      r_a  <= '0;
      r_b  <= '0;
    end else if (w_accept) begin
      r_op <= cmd_op;
      r_a  <= cmd_a;
      r_b  <= cmd_b;
    end
  end

  // Wait counter: zeroed while in ISSUE so it reads 0 on the first WAIT cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)                  r_cnt <= '0;
    else if (r_state == S_ISSUE) r_cnt <= '0;
    else if (r_state == S_WAIT)  r_cnt <= r_cnt + CNT_W'(1);
  end

  // Response capture: rejects in IDLE, ALU result or timeout in WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result <= '0;
      r_error  <= ERR_OK;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_illegal) begin
            r_result <= '0;
            r_error  <= ERR_ILLEGAL;
          end else if (w_accept && w_div0) begin
            r_result <= '0;
            r_error  <= ERR_DIV0;
          end
        end
        S_WAIT: begin
          if (alu_done) begin
            r_result <= alu_result;
            r_error  <= ERR_OK;
          end else if (w_timeout) begin
            r_result <= '0;
            r_error  <= ERR_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  assign operation_type = r_op;
  assign alu_a          = r_a;
  assign alu_b          = r_b;
  assign rsp_result     = r_result;
  assign rsp_error      = r_error;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_alu_command_issuer.sv
// Directed bench for alu_command_issuer: legal op latency, illegal opcode,
// divide-by-zero, timeout and its boundary, response back-pressure with a
// stray alu_done, and reset during WAIT.
module tb_alu_command_issuer;
  import alu_pkg::*;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 16;
  localparam int RW      = 2 * WIDTH;

  // Clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [3:0]       cmd_op    = '0;
  logic [WIDTH-1:0] cmd_a     = '0;
  logic [WIDTH-1:0] cmd_b     = '0;
  logic [3:0]       operation_type;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_start;
  logic             alu_done   = 1'b0;
  logic [RW-1:0]    alu_result = '0;
  logic             rsp_valid;
  logic             rsp_ready  = 1'b0;
  logic [RW-1:0]    rsp_result;
  logic [1:0]       rsp_error;
  logic [1:0]       dbg_state;

  alu_command_issuer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .operation_type(operation_type), .alu_a(alu_a), .alu_b(alu_b),
    .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_error(rsp_error),
    .dbg_state(dbg_state)
  );

  int err_cnt   = 0;
  int chk_cnt   = 0;
  int start_cnt = 0;
  logic [RW+1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    chk_cnt++;
    if (obs !== expv) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_state"},     dbg_state,      S_IDLE);
    check_eq({tag, "_cmd_ready"}, cmd_ready,      1);
    check_eq({tag, "_rsp_valid"}, rsp_valid,      0);
    check_eq({tag, "_alu_start"}, alu_start,      0);
    check_eq({tag, "_op"},        operation_type, 0);
    check_eq({tag, "_alu_a"},     alu_a,          0);
    check_eq({tag, "_alu_b"},     alu_b,          0);
    check_eq({tag, "_result"},    rsp_result,     0);
    check_eq({tag, "_error"},     rsp_error,      0);
  endtask

  // Offer one command; returns just after the accepting edge.
  task automatic send_cmd(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    check_eq("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Consume the held response; the monitor compares it with exp_q.
  task automatic take_rsp(input logic [1:0] err, input logic [RW-1:0] res);
    exp_q.push_back({err, res});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("back_to_idle", dbg_state, S_IDLE);
  endtask

  // Scoreboard monitor: counts start cycles and checks each handed-off response.
  always @(negedge clk) begin
    if (rst_n) begin
      if (alu_start) start_cnt++;
      if (rsp_valid && rsp_ready) begin
        check_eq("rsp_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check_eq("rsp_data", {rsp_error, rsp_result}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int n;
    int s0;

    // Reset
    rst_n = 1'b0;
    tick();
    tick();
    check_reset_values("rst");
    rst_n = 1'b1;
    tick();
    check_eq("rst_release_ready", cmd_ready, 1);

    // Stray alu_done in IDLE does nothing
    alu_done = 1'b1;
    tick();
    tick();
    alu_done = 1'b0;
    check_eq("idle_done_state", dbg_state, S_IDLE);
    check_eq("idle_done_valid", rsp_valid, 0);

    // ADD 5+3, alu_done the cycle after alu_start, result 8
    s0 = start_cnt;
    send_cmd(OP_ADD, 8'd5, 8'd3);
    check_eq("add_issue_state", dbg_state, S_ISSUE);
    check_eq("add_start",       alu_start, 1);
    check_eq("add_cmd_ready",   cmd_ready, 0);
    check_eq("add_op",          operation_type, 4'h7);
    check_eq("add_a",           alu_a, 5);
    check_eq("add_b",           alu_b, 3);
    tick();
    check_eq("add_wait_state",  dbg_state, S_WAIT);
    check_eq("add_start_off",   alu_start, 0);
    check_eq("add_no_valid_yet", rsp_valid, 0);
    alu_done   = 1'b1;
    alu_result = 16'd8;
    tick();
    alu_done   = 1'b0;
    check_eq("add_valid_cycle4", rsp_valid, 1);
    check_eq("add_result",      rsp_result, 8);
    check_eq("add_error",       rsp_error, ERR_OK);
    check_eq("add_op_hold",     operation_type, 4'h7);
    check_eq("add_a_hold",      alu_a, 5);
    take_rsp(ERR_OK, 16'd8);
    check_eq("add_start_pulses", start_cnt - s0, 1);

    // Illegal opcode 1100
    s0 = start_cnt;
    send_cmd(4'b1100, 8'd1, 8'd2);
    check_eq("ill_state",  dbg_state, S_RESP);
    check_eq("ill_valid",  rsp_valid, 1);
    check_eq("ill_error",  rsp_error, ERR_ILLEGAL);
    check_eq("ill_result", rsp_result, 0);
    take_rsp(ERR_ILLEGAL, '0);
    check_eq("ill_no_start", start_cnt - s0, 0);

    // DIV 9/0
    s0 = start_cnt;
    send_cmd(OP_DIV, 8'd9, 8'd0);
    check_eq("div0_state",  dbg_state, S_RESP);
    check_eq("div0_error",  rsp_error, ERR_DIV0);
    check_eq("div0_result", rsp_result, 0);
    take_rsp(ERR_DIV0, '0);
    check_eq("div0_no_start", start_cnt - s0, 0);

    // MUL with alu_done never arriving: timeout after 16 WAIT cycles
    alu_result = 16'hABCD;
    send_cmd(OP_MUL, 8'd7, 8'd6);
    tick();
    check_eq("to_wait_state", dbg_state, S_WAIT);
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    check_eq("to_wait_cycles", n, 16);
    check_eq("to_error",  rsp_error, ERR_TIMEOUT);
    check_eq("to_result", rsp_result, 0);
    take_rsp(ERR_TIMEOUT, '0);

    // MUL with alu_done exactly at counter 15: done wins
    send_cmd(OP_MUL, 8'd3, 8'd4);
    tick();
    for (int i = 0; i < 15; i++) tick();
    check_eq("edge_still_wait", dbg_state, S_WAIT);
    alu_done   = 1'b1;
    alu_result = 16'h1234;
    tick();
    alu_done   = 1'b0;
    check_eq("edge_valid",  rsp_valid, 1);
    check_eq("edge_error",  rsp_error, ERR_OK);
    check_eq("edge_result", rsp_result, 16'h1234);
    take_rsp(ERR_OK, 16'h1234);

    // Back-pressure: rsp_ready low for 10 cycles, stray alu_done in RESP
    send_cmd(OP_SUB, 8'd9, 8'd4);
    tick();
    alu_done   = 1'b1;
    alu_result = 16'd5;
    tick();
    alu_result = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      check_eq("bp_valid",     rsp_valid, 1);
      check_eq("bp_result",    rsp_result, 5);
      check_eq("bp_error",     rsp_error, ERR_OK);
      check_eq("bp_cmd_ready", cmd_ready, 0);
      tick();
    end
    alu_done = 1'b0;
    check_eq("bp_op_hold", operation_type, OP_SUB);
    take_rsp(ERR_OK, 16'd5);

    // Reset during WAIT: abandon the op, no response, no further start
    send_cmd(OP_AND, 8'hF0, 8'h3C);
    tick();
    tick();
    tick();
    check_eq("rw_in_wait", dbg_state, S_WAIT);
    s0 = start_cnt;
    rst_n = 1'b0;
    tick();
    check_reset_values("rw");
    rst_n = 1'b1;
    alu_done   = 1'b1;
    alu_result = 16'h00AA;
    tick();
    alu_done = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_eq("rw_stay_idle", dbg_state, S_IDLE);
    check_eq("rw_no_rsp",    rsp_valid, 0);
    check_eq("rw_no_start",  start_cnt - s0, 0);

    check_eq("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
